// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and helpers shared by the VGA pipeline
package vga_timing_pkg;

  localparam int unsigned COUNT_W = 10;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  localparam int unsigned VGA_X_MAX = VGA_H_DISPLAY - 1;
  localparam int unsigned VGA_Y_MAX = VGA_V_DISPLAY - 1;

  localparam int unsigned VGA_CLK_DIV     = 4;
  localparam bit          VGA_SYNC_ACTIVE = 1'b0;

  typedef logic [COUNT_W-1:0] coord_t;

  // A modulo-1 counter still needs one flop bit to keep the port legal.
  function automatic int unsigned counter_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic sync_level(input coord_t pos, input coord_t first,
                                      input coord_t last, input logic active);
    return ((pos >= first) && (pos <= last)) ? active : ~active;
  endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// rtl/vga_sync_generator_if.sv - scan timing bundle from the sync generator to pixel stages and pins
interface vga_sync_generator_if;
  import vga_timing_pkg::*;

  logic   o_p_tick;
  coord_t o_x;
  coord_t o_y;
  logic   o_video_on;
  logic   o_hsync;
  logic   o_vsync;
  logic   o_frame_tick;

  modport master (
    output o_p_tick, o_x, o_y, o_video_on, o_hsync, o_vsync, o_frame_tick
  );

  modport slave (
    input o_p_tick, o_x, o_y, o_video_on, o_hsync, o_vsync, o_frame_tick
  );

endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N counter with enable, next-value and wrap outputs
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = counter_width(N)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  if ((N < 1) || (N > (1 << W))) begin : g_bad_modulus
    $error("mod_counter: modulus does not fit the counter width");
  end

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap_o = en_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - pixel-rate enable, scan counters, syncs and frame pulse for VGA output
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_DISPLAY   = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter bit          SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  vga_sync_generator_if.master vga
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = counter_width(CLK_DIV);

  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_timing
    $error("vga_sync_generator: timing parameters out of range");
  end

  logic [DIV_W-1:0] div_count_unused;
  logic [DIV_W-1:0] div_next_unused;
  logic             div_wrap;
  coord_t           h_count, h_next, v_count, v_next;
  logic             h_wrap, v_wrap;

  logic p_tick_q, p_tick_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic frame_tick_q, frame_tick_d;

  mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .en_i    (1'b1),
    .count_o (div_count_unused),
    .next_o  (div_next_unused),
    .wrap_o  (div_wrap)
  );

  mod_counter #(.N(H_TOTAL), .W(COUNT_W)) u_h (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .en_i    (p_tick_q),
    .count_o (h_count),
    .next_o  (h_next),
    .wrap_o  (h_wrap)
  );

  mod_counter #(.N(V_TOTAL), .W(COUNT_W)) u_v (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .en_i    (h_wrap),
    .count_o (v_count),
    .next_o  (v_next),
    .wrap_o  (v_wrap)
  );

  // Syncs decode the counters' next values so they land on the same edge as o_x/o_y.
  always_comb begin
    p_tick_d     = div_wrap;
    hsync_d      = sync_level(h_next, HS_START, HS_END, SYNC_ACTIVE);
    vsync_d      = sync_level(v_next, VS_START, VS_END, SYNC_ACTIVE);
    frame_tick_d = v_wrap;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      p_tick_q     <= 1'b0;
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      frame_tick_q <= 1'b0;
    end else begin
      p_tick_q     <= p_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.o_p_tick     = p_tick_q;
  assign vga.o_x          = h_count;
  assign vga.o_y          = v_count;
  assign vga.o_video_on   = (h_count < H_VIS) && (v_count < V_VIS);
  assign vga.o_hsync      = hsync_q;
  assign vga.o_vsync      = vsync_q;
  assign vga.o_frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - scoreboard bench: default timing, CLK_DIV=1 active-high, and a tiny frame
module tb_vga_sync_generator;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
  } exp_t;

  typedef struct packed {
    int d, hd, hf, hs, hb, vd, vf, vs, vb;
    bit act;
  } cfg_t;

  localparam cfg_t CFG_A = '{d:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, act:1'b0};
  localparam cfg_t CFG_B = '{d:1, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, act:1'b1};
  localparam cfg_t CFG_C = '{d:2, hd:16, hf:2, hs:3, hb:3, vd:8, vf:2, vs:2, vb:2, act:1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k_edge = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t ea, eb, ec;
  exp_t got_a, got_b, got_c;

  always #5 clk = ~clk;

  vga_sync_generator_if bus_a();
  vga_sync_generator_if bus_b();
  vga_sync_generator_if bus_c();

  vga_sync_generator u_dut_a (.i_clk(clk), .i_reset(rst), .vga(bus_a));

  vga_sync_generator #(.CLK_DIV(1), .SYNC_ACTIVE(1'b1)) u_dut_b (.i_clk(clk), .i_reset(rst), .vga(bus_b));

  vga_sync_generator #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)
  ) u_dut_c (.i_clk(clk), .i_reset(rst), .vga(bus_c));

  assign got_a = {bus_a.o_p_tick, bus_a.o_x, bus_a.o_y, bus_a.o_video_on, bus_a.o_hsync, bus_a.o_vsync, bus_a.o_frame_tick};
  assign got_b = {bus_b.o_p_tick, bus_b.o_x, bus_b.o_y, bus_b.o_video_on, bus_b.o_hsync, bus_b.o_vsync, bus_b.o_frame_tick};
  assign got_c = {bus_c.o_p_tick, bus_c.o_x, bus_c.o_y, bus_c.o_video_on, bus_c.o_hsync, bus_c.o_vsync, bus_c.o_frame_tick};

  // Expected outputs after k clock edges since reset release, from the timing arithmetic alone.
  function automatic exp_t model(input cfg_t c, input int k);
    int ht, vt, n, n_prev, p, x, y;
    exp_t e;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    n = (k < 1) ? 0 : (k - 1) / c.d;
    n_prev = (k < 2) ? 0 : (k - 2) / c.d;
    p = n % (ht * vt);
    x = p % ht;
    y = p / ht;
    e.p_tick = (k > 0) && (k % c.d == 0);
    e.x = x[9:0];
    e.y = y[9:0];
    e.video_on = (x < c.hd) && (y < c.vd);
    e.hsync = ((x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs)) ? c.act : !c.act;
    e.vsync = ((y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs)) ? c.act : !c.act;
    e.frame_tick = (n != n_prev) && (p == 0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) k_edge++;
    q_a.push_back(model(CFG_A, k_edge));
    q_b.push_back(model(CFG_B, k_edge));
    q_c.push_back(model(CFG_C, k_edge));
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front();
      n_compared += 3;
      if (got_a !== ea) begin n_mismatched++; $display("FAIL reset_a k=%0d got=%h want=%h", k_edge, got_a, ea); end
      if (got_b !== eb) begin n_mismatched++; $display("FAIL reset_b k=%0d got=%h want=%h", k_edge, got_b, eb); end
      if (got_c !== ec) begin n_mismatched++; $display("FAIL reset_c k=%0d got=%h want=%h", k_edge, got_c, ec); end
    end
    rst = 1'b0;
  endtask

  task automatic test_tick_cadence();
    int first_tick = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (first_tick < 0 && got_a.p_tick === 1'b1) first_tick = k_edge;
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front();
      n_compared += 3;
      if (got_a !== ea) begin n_mismatched++; $display("FAIL cadence_a k=%0d got=%h want=%h", k_edge, got_a, ea); end
      if (got_b !== eb) begin n_mismatched++; $display("FAIL cadence_b k=%0d got=%h want=%h", k_edge, got_b, eb); end
      if (got_c !== ec) begin n_mismatched++; $display("FAIL cadence_c k=%0d got=%h want=%h", k_edge, got_c, ec); end
    end
    n_compared++;
    if (first_tick != 4) begin
      n_mismatched++;
      $display("FAIL first_tick_edge got=%0d want=4", first_tick);
    end
  endtask

  task automatic test_line_wrap();
    int hs_low_a = 0;
    int hs_high_b = 0;
    int frames_c = 0;
    int exp_frames;
    int start_inc;
    start_inc = (k_edge - 1) / CFG_C.d;
    for (int i = 0; i < 3300; i++) begin
      step();
      if (got_a.hsync === 1'b0) hs_low_a++;
      if (got_b.hsync === 1'b1) hs_high_b++;
      if (got_c.frame_tick === 1'b1) frames_c++;
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front();
      n_compared += 3;
      if (got_a !== ea) begin n_mismatched++; $display("FAIL line_a k=%0d got=%h want=%h", k_edge, got_a, ea); end
      if (got_b !== eb) begin n_mismatched++; $display("FAIL line_b k=%0d got=%h want=%h", k_edge, got_b, eb); end
      if (got_c !== ec) begin n_mismatched++; $display("FAIL line_c k=%0d got=%h want=%h", k_edge, got_c, ec); end
    end
    exp_frames = ((k_edge - 1) / CFG_C.d) / (24 * 14) - start_inc / (24 * 14);
    n_compared += 3;
    if (hs_low_a != 384) begin n_mismatched++; $display("FAIL hsync_low_clocks_a got=%0d want=384", hs_low_a); end
    if (hs_high_b != 384) begin n_mismatched++; $display("FAIL hsync_high_clocks_b got=%0d want=384", hs_high_b); end
    if (frames_c != exp_frames) begin n_mismatched++; $display("FAIL frame_ticks_c got=%0d want=%0d", frames_c, exp_frames); end
  endtask

  task automatic test_mid_frame_reset();
    bit hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front();
      n_compared += 3;
      if (got_a !== ea) begin n_mismatched++; $display("FAIL seek_a k=%0d got=%h want=%h", k_edge, got_a, ea); end
      if (got_b !== eb) begin n_mismatched++; $display("FAIL seek_b k=%0d got=%h want=%h", k_edge, got_b, eb); end
      if (got_c !== ec) begin n_mismatched++; $display("FAIL seek_c k=%0d got=%h want=%h", k_edge, got_c, ec); end
      if (got_a.x === 10'd300) hit = 1'b1;
    end
    n_compared++;
    if (!hit) begin n_mismatched++; $display("FAIL seek_x300 got=timeout want=x300"); end
    // Reset lands between edges; outputs must clear before the next posedge.
    #2;
    rst = 1'b1;
    k_edge = 0;
    #1;
    ea = model(CFG_A, 0); eb = model(CFG_B, 0); ec = model(CFG_C, 0);
    n_compared += 3;
    if (got_a !== ea) begin n_mismatched++; $display("FAIL async_reset_a got=%h want=%h", got_a, ea); end
    if (got_b !== eb) begin n_mismatched++; $display("FAIL async_reset_b got=%h want=%h", got_b, eb); end
    if (got_c !== ec) begin n_mismatched++; $display("FAIL async_reset_c got=%h want=%h", got_c, ec); end
    for (int i = 0; i < 803; i++) begin
      step();
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front();
      n_compared += 3;
      if (got_a !== ea) begin n_mismatched++; $display("FAIL restart_a k=%0d got=%h want=%h", k_edge, got_a, ea); end
      if (got_b !== eb) begin n_mismatched++; $display("FAIL restart_b k=%0d got=%h want=%h", k_edge, got_b, eb); end
      if (got_c !== ec) begin n_mismatched++; $display("FAIL restart_c k=%0d got=%h want=%h", k_edge, got_c, ec); end
      if (i == 2) rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_tick_cadence();
    test_line_wrap();
    test_mid_frame_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
